// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared command encodings, default widths and small decode
//                helpers for the memory request/response responder.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_responder_pkg;

    // Request command encoding carried on i_cmd
    typedef enum logic [1:0] {
        MEM_CMD_NOP   = 2'b00,
        MEM_CMD_READ  = 2'b01,
        MEM_CMD_WRITE = 2'b10,
        MEM_CMD_RSVD  = 2'b11
    } mem_cmd_e;

    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    function automatic logic is_read(input logic [1:0] cmd);
        return cmd == MEM_CMD_READ;
    endfunction

    function automatic logic is_write(input logic [1:0] cmd);
        return cmd == MEM_CMD_WRITE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : resp_fifo
//  Description : Small synchronous FIFO holding read responses. Pointers carry
//                an extra wrap bit so full and empty are distinguished without
//                a separate occupancy counter. Output reads zero when empty.
//  Revision    : 1.0  initial release
// ============================================================================
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [IDX_W:0]   wr_ptr;
    logic [IDX_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Step a pointer, wrapping the index and toggling the wrap bit at DEPTH-1
    function automatic logic [IDX_W:0] advance(input logic [IDX_W:0] ptr);
        if (ptr[IDX_W-1:0] == LAST_IDX) begin
            return {~ptr[IDX_W], {IDX_W{1'b0}}};
        end
        return ptr + (IDX_W + 1)'(1);
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : storage[rd_ptr[IDX_W-1:0]];

    // Storage has no reset; only slots between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    // Pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= advance(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= advance(rd_ptr);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Responder end of the memory request/response interface.
//                Writes land in a word array; reads sample the array at
//                accept, ride a fixed-latency pipe into an in-order response
//                FIFO, and are returned under requester backpressure. A credit
//                counter covering in-flight plus queued reads gates o_ready so
//                the FIFO can never overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2    = 10,
    parameter int LATENCY       = 2,
    parameter int QUEUE_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [1:0]               i_cmd,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_res_ready,
    output logic                     o_ready,
    output logic                     o_res_valid,
    output logic [DATA_WIDTH-1:0]    o_data
);

    localparam int WORDS    = 1 << DEPTH_LOG2;
    localparam int CREDIT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DEPTH_LOG2-1:0] index;
    logic                  accept;
    logic                  read_accept;
    logic                  write_accept;
    logic                  pop;
    logic [LATENCY-1:0]    pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
    logic [CREDIT_W-1:0]   credits;
    logic [CREDIT_W-1:0]   credits_next;
    logic                  ready_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_bits;

    // Word index; byte offset and bits above the array alias away
    assign index        = i_address[DEPTH_LOG2+1:2];
    assign accept       = i_valid & ready_q;
    assign read_accept  = accept & is_read(i_cmd);
    assign write_accept = accept & is_write(i_cmd);

    assign o_ready      = ready_q;
    assign o_res_valid  = ~fifo_empty;
    assign pop          = o_res_valid & i_res_ready;

    assign credits_next = credits + CREDIT_W'(read_accept) - CREDIT_W'(pop);

    assign unused_bits  = ^{i_address[ADDRESS_WIDTH-1:DEPTH_LOG2+2],
                            i_address[1:0], fifo_full};

    // Array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (write_accept) begin
            mem[index] <= i_data;
        end
    end

    // Latency pipe: stage 0 samples the array at accept, later stages shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= read_accept;
            if (read_accept) begin
                pipe_data[0] <= mem[index];
            end
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_data[s]  <= pipe_data[s-1];
            end
        end
    end

    // Credit counter and registered ready derived from the updated count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= '0;
            ready_q <= 1'b0;
        end else begin
            credits <= credits_next;
            ready_q <= (credits_next < CREDIT_MAX);
        end
    end

    resp_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid[LATENCY-1]),
        .push_data (pipe_data[LATENCY-1]),
        .pop       (pop),
        .pop_data  (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. A reference model
//                tracks array contents and the list of outstanding reads with
//                the cycle each becomes visible; outputs are compared against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DL    = 10;
    localparam int LAT   = 2;
    localparam int QD    = 2;
    localparam int WORDS = 1 << DL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_valid = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [1:0]    i_cmd = 2'b00;
    logic [DW-1:0] i_data = '0;
    logic          i_res_ready = 1'b0;
    logic          o_ready;
    logic          o_res_valid;
    logic [DW-1:0] o_data;

    mem_responder #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH_LOG2    (DL),
        .LATENCY       (LAT),
        .QUEUE_DEPTH   (QD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_address   (i_address),
        .i_cmd       (i_cmd),
        .i_data      (i_data),
        .i_res_ready (i_res_ready),
        .o_ready     (o_ready),
        .o_res_valid (o_res_valid),
        .o_data      (o_data)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        int            due;
    } resp_t;

    resp_t         q[$];
    logic [DW-1:0] mem_model [WORDS];
    bit            known [WORDS];
    int            cyc = 0;
    bit            m_ready = 1'b0;
    bit            last_acc = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // A read is visible once the edge count reaches its due cycle
    function automatic bit exp_valid();
        return (reset === 1'b1) && (q.size() > 0) && (q[0].due <= cyc);
    endfunction

    task automatic drive(input bit v, input logic [1:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        i_valid   = v;
        i_cmd     = c;
        i_address = a;
        i_data    = d;
    endtask

    task automatic model_reset();
        reset   = 1'b0;
        q.delete();
        m_ready = 1'b0;
    endtask

    // Advance one clock edge and update the model with the spec's rules
    task automatic step();
        int idx;
        bit pop;
        @(posedge clk);
        last_acc = (reset === 1'b1) && i_valid && m_ready;
        pop      = i_res_ready && exp_valid();
        if (pop) void'(q.pop_front());
        if (last_acc) begin
            idx = int'(i_address[DL+1:2]);
            if (i_cmd == MEM_CMD_READ) begin
                q.push_back('{data: mem_model[idx], known: known[idx], due: cyc + 1 + LAT});
            end else if (i_cmd == MEM_CMD_WRITE) begin
                mem_model[idx] = i_data;
                known[idx]     = 1'b1;
            end
        end
        cyc++;
        m_ready = (reset === 1'b1) && (q.size() < QD);
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_res_ready = 1'b1;
        drive(1'b1, MEM_CMD_READ, 32'h0, 32'h0);
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (o_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready: got %b expected 0", o_ready);
            end
            checks++;
            if (o_res_valid !== 1'b0) begin
                errors++; $display("FAIL reset_res_valid: got %b expected 0", o_res_valid);
            end
            checks++;
            if (o_data !== '0) begin
                errors++; $display("FAIL reset_data: got %h expected 0", o_data);
            end
        end
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        checks++;
        if (o_ready !== m_ready) begin
            errors++; $display("FAIL release_ready: got %b expected %b", o_ready, m_ready);
        end
    endtask

    task automatic test_write_read();
        int            acc_cyc;
        int            seen;
        logic [DW-1:0] first_data;
        i_res_ready = 1'b1;
        drive(1'b1, MEM_CMD_WRITE, 32'h10, 32'hDEADBEEF);
        step();
        drive(1'b1, MEM_CMD_READ, 32'h10, 32'h0);
        step();
        acc_cyc = cyc;
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        seen = -1;
        first_data = '0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (o_res_valid !== exp_valid()) begin
                errors++; $display("FAIL raw_valid: got %b expected %b cycle %0d", o_res_valid, exp_valid(), cyc);
            end
            if (o_res_valid === 1'b1 && seen < 0) begin
                seen = cyc;
                first_data = o_data;
            end
            step();
        end
        checks++;
        if (seen - acc_cyc != LAT) begin
            errors++; $display("FAIL raw_latency: got %0d expected %0d", seen - acc_cyc, LAT);
        end
        checks++;
        if (first_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL raw_data: got %h expected deadbeef", first_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got[$];
        logic [DW-1:0] want [3];
        int            sent;
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
        i_res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, MEM_CMD_WRITE, AW'(i * 4), want[i]);
            step();
        end
        sent = 0;
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (o_ready !== m_ready) begin
                errors++; $display("FAIL b2b_ready: got %b expected %b cycle %0d", o_ready, m_ready, cyc);
            end
            checks++;
            if (o_res_valid !== exp_valid()) begin
                errors++; $display("FAIL b2b_valid: got %b expected %b cycle %0d", o_res_valid, exp_valid(), cyc);
            end
            if (o_res_valid === 1'b1) got.push_back(o_data);
            if (sent < 3) drive(1'b1, MEM_CMD_READ, AW'(sent * 4), 32'h0);
            else          drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
            step();
            if (last_acc) sent++;
        end
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] r[2];
        logic [DW-1:0] got[$];
        int            accepted;
        r[0] = $urandom; r[1] = $urandom;
        i_res_ready = 1'b1;
        drive(1'b1, MEM_CMD_WRITE, 32'h20, r[0]); step();
        drive(1'b1, MEM_CMD_WRITE, 32'h24, r[1]); step();
        i_res_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_ready !== m_ready) begin
                errors++; $display("FAIL bp_ready: got %b expected %b cycle %0d", o_ready, m_ready, cyc);
            end
            drive(1'b1, MEM_CMD_READ, 32'h20 + AW'(accepted * 4), 32'h0);
            step();
            if (last_acc) accepted++;
        end
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (o_ready !== 1'b0 || o_res_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold: got ready=%b valid=%b expected ready=0 valid=1", o_ready, o_res_valid);
            end
            checks++;
            if (o_data !== r[0]) begin
                errors++; $display("FAIL bp_stable: got %h expected %h", o_data, r[0]);
            end
            step();
        end
        i_res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (o_ready !== m_ready) begin
                errors++; $display("FAIL bp_release_ready: got %b expected %b iter %0d", o_ready, m_ready, i);
            end
            if (o_res_valid === 1'b1) got.push_back(o_data);
            step();
        end
        checks++;
        if (got.size() != 2 || got[0] !== r[0] || got[1] !== r[1]) begin
            errors++; $display("FAIL bp_order: got %0d responses first %h expected %h then %h",
                               got.size(), (got.size() > 0) ? got[0] : '0, r[0], r[1]);
        end
    endtask

    task automatic test_alias();
        logic [DW-1:0] got;
        bit            any;
        i_res_ready = 1'b1;
        drive(1'b1, MEM_CMD_WRITE, 32'h1003, 32'hA5); step();
        drive(1'b1, MEM_CMD_READ, 32'h0000, 32'h0); step();
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        any = 1'b0; got = '0;
        for (int i = 0; i < 5; i++) begin
            if (o_res_valid === 1'b1) begin any = 1'b1; got = o_data; end
            step();
        end
        checks++;
        if (!any || got !== 32'hA5) begin
            errors++; $display("FAIL alias: got %h (seen %b) expected a5", got, any);
        end
    endtask

    task automatic test_unknown_cmd();
        logic [DW-1:0] got[$];
        i_res_ready = 1'b1;
        drive(1'b1, MEM_CMD_WRITE, 32'h40, 32'h12345678); step();
        drive(1'b1, MEM_CMD_NOP,   32'h40, 32'hFFFFFFFF); step();
        drive(1'b1, MEM_CMD_RSVD,  32'h40, 32'hFFFFFFFF); step();
        drive(1'b1, MEM_CMD_READ,  32'h40, 32'h0);        step();
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (o_res_valid === 1'b1) got.push_back(o_data);
            step();
        end
        checks++;
        if (got.size() != 1 || got[0] !== 32'h12345678) begin
            errors++; $display("FAIL unknown_cmd: got %0d responses first %h expected 1 of 12345678",
                               got.size(), (got.size() > 0) ? got[0] : '0);
        end
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] v;
        logic [DW-1:0] got[$];
        v = $urandom;
        i_res_ready = 1'b1;
        drive(1'b1, MEM_CMD_WRITE, 32'h30, v); step();
        drive(1'b1, MEM_CMD_READ,  32'h30, 32'h0); step();
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        model_reset();
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_res_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got ready=%b valid=%b expected 0 0", o_ready, o_res_valid);
        end
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (o_res_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_ghost: got valid=%b expected 0 iter %0d", o_res_valid, i);
            end
        end
        drive(1'b1, MEM_CMD_READ, 32'h30, 32'h0); step();
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (o_res_valid === 1'b1) got.push_back(o_data);
            step();
        end
        checks++;
        if (got.size() != 1 || got[0] !== v) begin
            errors++; $display("FAIL midrst_read: got %0d responses first %h expected 1 of %h",
                               got.size(), (got.size() > 0) ? got[0] : '0, v);
        end
    endtask

    task automatic test_random();
        int idx;
        i_res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, MEM_CMD_WRITE, AW'(i * 4), $urandom);
            step();
            if (!last_acc) i--;
        end
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (o_ready !== m_ready) begin
                errors++; $display("FAIL rand_ready: got %b expected %b cycle %0d", o_ready, m_ready, cyc);
            end
            checks++;
            if (o_res_valid !== exp_valid()) begin
                errors++; $display("FAIL rand_valid: got %b expected %b cycle %0d", o_res_valid, exp_valid(), cyc);
            end
            if (exp_valid() && q[0].known) begin
                checks++;
                if (o_data !== q[0].data) begin
                    errors++; $display("FAIL rand_data: got %h expected %h cycle %0d", o_data, q[0].data, cyc);
                end
            end
            idx = int'($urandom_range(0, 15));
            drive(($urandom % 4) != 0, 2'($urandom % 4),
                  ($urandom & 32'hFFFF_F000) | AW'(idx * 4) | AW'($urandom % 4), $urandom);
            i_res_ready = ($urandom % 3) != 0;
            step();
        end
        drive(1'b0, MEM_CMD_NOP, 32'h0, 32'h0);
        i_res_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (o_res_valid !== 1'b0 || q.size() != 0) begin
            errors++; $display("FAIL rand_drain: got valid=%b expected 0 with %0d model entries", o_res_valid, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_alias();
        test_unknown_cmd();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
